// File: rtl/cursor_controller_rpt.sv
// Five-button cursor controller: per-button sync + debounce, auto-repeat on the direction
// buttons, saturating or wrapping cursor movement over a GRID_W x GRID_H grid.
module cursor_controller_rpt #(
  parameter int unsigned GRID_W          = 80,
  parameter int unsigned GRID_H          = 60,
  parameter int unsigned X_W             = 7,
  parameter int unsigned Y_W             = 6,
  parameter int unsigned START_X         = 40,
  parameter int unsigned START_Y         = 30,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           btnU,
  input  logic           btnD,
  input  logic           btnL,
  input  logic           btnR,
  input  logic           btnC,
  input  logic           wrap_en,
  output logic [X_W-1:0] cursorX,
  output logic [Y_W-1:0] cursorY,
  output logic           moved,
  output logic           toggle
);
  localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RcW    = $clog2(RptMax + 1);

  typedef enum logic [1:0] {StIdle, StHold, StRepeat} rpt_st_e;

  // Bit order: 0=U, 1=D, 2=L, 3=R, 4=C
  logic [4:0]             btn_raw;
  logic [SYNC_STAGES-1:0] sync_q   [5];
  logic [DbW-1:0]         db_cnt_q [5];
  logic [4:0]             deb_q;

  assign btn_raw = {btnC, btnR, btnL, btnD, btnU};

  always_ff @(posedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (!rst_n) begin
        sync_q[i]   <= '0;
        db_cnt_q[i] <= '0;
        deb_q[i]    <= 1'b0;
      end else begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], btn_raw[i]};
        if (sync_q[i][SYNC_STAGES-1] == deb_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DbW'(DEBOUNCE_CYCLES - 1)) begin
          deb_q[i]    <= ~deb_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  rpt_st_e        rpt_st_q  [4];
  logic [RcW-1:0] rpt_cnt_q [4];
  logic [3:0]     step;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      step[i] = 1'b0;
      unique case (rpt_st_q[i])
        StIdle:   step[i] = deb_q[i];
        StHold:   step[i] = deb_q[i] && (REPEAT_DELAY != 0) &&
                            (rpt_cnt_q[i] == RcW'(REPEAT_DELAY - 1));
        StRepeat: step[i] = deb_q[i] && (rpt_cnt_q[i] == RcW'(REPEAT_PERIOD - 1));
        default:  step[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst_n || !deb_q[i]) begin
        rpt_st_q[i]  <= StIdle;
        rpt_cnt_q[i] <= '0;
      end else begin
        unique case (rpt_st_q[i])
          StIdle: begin
            rpt_st_q[i]  <= StHold;
            rpt_cnt_q[i] <= '0;
          end
          StHold: begin
            // A zero delay parks the FSM here: one step per press, no repeat.
            if (REPEAT_DELAY == 0) begin
              rpt_cnt_q[i] <= rpt_cnt_q[i];
            end else if (step[i]) begin
              rpt_st_q[i]  <= StRepeat;
              rpt_cnt_q[i] <= '0;
            end else begin
              rpt_cnt_q[i] <= rpt_cnt_q[i] + RcW'(1);
            end
          end
          StRepeat: begin
            if (step[i]) rpt_cnt_q[i] <= '0;
            else         rpt_cnt_q[i] <= rpt_cnt_q[i] + RcW'(1);
          end
          default: begin
            rpt_st_q[i]  <= StIdle;
            rpt_cnt_q[i] <= '0;
          end
        endcase
      end
    end
  end

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           moved_q, toggle_q, c_prev_q, c_edge_q;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (step[3] && !step[2]) begin
      x_d = (x_q != X_W'(GRID_W - 1)) ? x_q + X_W'(1) : (wrap_en ? '0 : x_q);
    end else if (step[2] && !step[3]) begin
      x_d = (x_q != '0) ? x_q - X_W'(1) : (wrap_en ? X_W'(GRID_W - 1) : x_q);
    end
    if (step[1] && !step[0]) begin
      y_d = (y_q != Y_W'(GRID_H - 1)) ? y_q + Y_W'(1) : (wrap_en ? '0 : y_q);
    end else if (step[0] && !step[1]) begin
      y_d = (y_q != '0) ? y_q - Y_W'(1) : (wrap_en ? Y_W'(GRID_H - 1) : y_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q      <= X_W'(START_X);
      y_q      <= Y_W'(START_Y);
      moved_q  <= 1'b0;
      c_prev_q <= 1'b0;
      c_edge_q <= 1'b0;
      toggle_q <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      moved_q  <= (x_d != x_q) || (y_d != y_q);
      c_prev_q <= deb_q[4];
      c_edge_q <= deb_q[4] & ~c_prev_q;
      toggle_q <= c_edge_q;
    end
  end

  assign cursorX = x_q;
  assign cursorY = y_q;
  assign moved   = moved_q;
  assign toggle  = toggle_q;

endmodule
